// File: rtl/i2s_rx_pkg.sv
// I2S receiver shared definitions.
// FSM encodings and word-select polarity.
package i2s_rx_pkg;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } i2s_state_t;

    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

    // Counter width able to hold 0..w inclusive.
    function automatic int cnt_bits(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/i2s_rx_sync_edge.sv
// Two-flop synchronisers for the I2S pins.
// The bit clock lane also yields a rising-edge pulse.
module i2s_rx_sync_edge #(
    parameter int W = 2
) (
    input  logic         ck,
    input  logic         rst_n,
    input  logic         edge_in,
    input  logic [W-1:0] data_in,
    output logic         rise,
    output logic [W-1:0] data_q
);

    logic         e_meta;
    logic         e_sync;
    logic         e_prev;
    logic [W-1:0] d_meta;
    logic [W-1:0] d_sync;

    // Bit clock: two-stage sync plus one history flop for edge detection.
    always_ff @(posedge ck) begin
        if (!rst_n) begin
            e_meta <= 1'b0;
            e_sync <= 1'b0;
            e_prev <= 1'b0;
        end else begin
            e_meta <= edge_in;
            e_sync <= e_meta;
            e_prev <= e_sync;
        end
    end

    // Data lanes: two-stage sync only.
    always_ff @(posedge ck) begin
        if (!rst_n) begin
            d_meta <= '0;
            d_sync <= '0;
        end else begin
            d_meta <= data_in;
            d_sync <= d_meta;
        end
    end

    assign rise   = e_sync & ~e_prev;
    assign data_q = d_sync;

endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver, oversampled on ck.
// Emits one left/right pair per frame with a valid strobe.
module i2s_rx #(
    parameter int WIDTH = 16
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic             sck,
    input  logic             ws,
    input  logic             sd,
    output logic [WIDTH-1:0] data_l,
    output logic [WIDTH-1:0] data_r,
    output logic             valid,
    output logic             short
);

    import i2s_rx_pkg::*;

    localparam int CW = cnt_bits(WIDTH);
    localparam logic [WIDTH-1:0] MSB_BIT = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    logic             sck_rise;
    logic [1:0]       bus_q;
    logic             ws_s;
    logic             sd_s;
    logic             ws_p;
    logic             ws_chg;

    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] app_word;
    logic [CW-1:0]    app_cnt;
    logic             app_short;

    logic [WIDTH-1:0] hold_l;
    logic             hold_short;

    i2s_state_t       state;
    i2s_state_t       state_n;
    logic             load_hold;
    logic             load_out;

    i2s_rx_sync_edge #(
        .W (2)
    ) u_sync (
        .ck      (ck),
        .rst_n   (rst_n),
        .edge_in (sck),
        .data_in ({ws, sd}),
        .rise    (sck_rise),
        .data_q  (bus_q)
    );

    assign ws_s   = bus_q[1];
    assign sd_s   = bus_q[0];
    assign ws_chg = sck_rise && (ws_s != ws_p);

    // Channel word with the current sd bit appended (dropped once full).
    always_comb begin
        bit_mask = MSB_BIT >> cnt;
        app_word = shreg;
        app_cnt  = cnt;
        if (cnt < FULL) begin
            app_word = shreg | ({WIDTH{sd_s}} & bit_mask);
            app_cnt  = cnt + CW'(1);
        end
        app_short = (app_cnt < FULL);
    end

    // Remember ws from the previous bit clock to spot channel changes.
    always_ff @(posedge ck) begin
        if (!rst_n) begin
            ws_p <= WS_LEFT;
        end else if (sck_rise) begin
            ws_p <= ws_s;
        end
    end

    // Shift register and saturating bit count; restart on channel change.
    always_ff @(posedge ck) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (sck_rise) begin
            if (ws_chg) begin
                shreg <= '0;
                cnt   <= '0;
            end else begin
                shreg <= app_word;
                cnt   <= app_cnt;
            end
        end
    end

    // Frame state register.
    always_ff @(posedge ck) begin
        if (!rst_n) begin
            state <= ST_SYNC;
        end else begin
            state <= state_n;
        end
    end

    // Frame sequencing: align on a right->left change, then alternate.
    always_comb begin
        state_n   = state;
        load_hold = 1'b0;
        load_out  = 1'b0;
        if (ws_chg) begin
            unique case (state)
                ST_SYNC: begin
                    if (ws_s == WS_LEFT) begin
                        state_n = ST_LEFT;
                    end
                end
                ST_LEFT: begin
                    if (ws_s == WS_RIGHT) begin
                        load_hold = 1'b1;
                        state_n   = ST_RIGHT;
                    end
                end
                ST_RIGHT: begin
                    if (ws_s == WS_LEFT) begin
                        load_out = 1'b1;
                        state_n  = ST_LEFT;
                    end
                end
                default: begin
                    state_n = ST_SYNC;
                end
            endcase
        end
    end

    // Park the finished left word until its right partner closes.
    always_ff @(posedge ck) begin
        if (!rst_n) begin
            hold_l     <= '0;
            hold_short <= 1'b0;
        end else if (load_hold) begin
            hold_l     <= app_word;
            hold_short <= app_short;
        end
    end

    // Publish the pair with a one-cycle strobe.
    always_ff @(posedge ck) begin
        if (!rst_n) begin
            data_l <= '0;
            data_r <= '0;
            short  <= 1'b0;
            valid  <= 1'b0;
        end else begin
            valid <= load_out;
            if (load_out) begin
                data_l <= hold_l;
                data_r <= app_word;
                short  <= hold_short | app_short;
            end
        end
    end

endmodule
